// File: rtl/frac_lut6_cfg_seq.sv
// Configuration sequencer for a fractured LUT6 latch memory: captures one 64-bit
// truth-table word and programs it bit-serially by pulsing one word line at a time.
module frac_lut6_cfg_seq #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned WL_PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC     = 1
) (
  input  logic        prog_clk,
  input  logic        pReset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [0:63] cfg_data,
  output logic [0:63] bl,
  output logic [0:63] wl,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // Handshake: a word is taken on any rising edge where cfg_valid and cfg_ready
  // are both high; cfg_ready is high only in IDLE, so cfg_valid/cfg_data are
  // don't-care for the whole programming sequence.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Phase counter counts down from (length-1) and leaves the state at zero.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(WL_PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [0:63] word_q, word_d;
  logic [0:63] bl_q, bl_d;
  logic [0:63] wl_q, wl_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d = ST_SETUP;
          word_d  = cfg_data;
          idx_d   = 6'd0;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          if (idx_q == 6'd63) begin
            state_d = ST_DONE;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_PULSE;
            idx_d   = idx_q + 6'd1;
            cnt_d   = PULSE_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // bl/wl are computed from the next state so the registered copies line up
  // exactly with the state register, with no input-to-output path.
  always_comb begin
    bl_d = '0;
    wl_d = '0;
    if (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD)
      bl_d = word_d;
    if (state_d == ST_PULSE)
      wl_d[idx_d] = 1'b1;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= 8'd0;
      word_q  <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_frac_lut6_cfg_seq.sv
// Bench for frac_lut6_cfg_seq: default-parameter instance plus a (2,3,2) instance,
// both checked cycle by cycle against a timeline model of the programming sequence.
module tb_frac_lut6_cfg_seq;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        cfg_valid_a, cfg_valid_b;
  logic [0:63] cfg_data;
  logic        cfg_ready_a, cfg_ready_b;
  logic [0:63] bl_a, wl_a, bl_b, wl_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 prog_clk = ~prog_clk;

  frac_lut6_cfg_seq dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .cfg_data(cfg_data), .bl(bl_a), .wl(wl_a), .busy(busy_a), .done(done_a),
    .dbg_state(dbg_state_a)
  );

  frac_lut6_cfg_seq #(.SETUP_CYC(2), .WL_PULSE_CYC(3), .HOLD_CYC(2)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_data(cfg_data), .bl(bl_b), .wl(wl_b), .busy(busy_b), .done(done_b),
    .dbg_state(dbg_state_b)
  );

  // Timeline model: cycle c counts from the accept edge (c = 0).
  function automatic logic [0:63] exp_wl(int c, int s, int w, int h);
    logic [0:63] v;
    int t, p;
    v = '0;
    p = w + h;
    t = c - 1 - s;
    if (t >= 0 && t < 64 * p && (t % p) < w) v[t / p] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:63] exp_bl(int c, int s, int w, int h, logic [0:63] word);
    if (c >= 1 && c <= s + 64 * (w + h)) return word;
    return '0;
  endfunction

  function automatic int done_cyc(int s, int w, int h);
    return s + 64 * (w + h) + 1;
  endfunction

  function automatic logic [0:63] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic test_reset();
    pReset      = 1'b1;
    cfg_valid_a = 1'b1;
    cfg_valid_b = 1'b1;
    cfg_data    = rand_word();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (wl_a !== '0 || bl_a !== '0 || done_a !== 1'b0 || cfg_ready_a !== 1'b1 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_a cyc=%0d wl=%h bl=%h done=%b rdy=%b busy=%b exp wl=0 bl=0 done=0 rdy=1 busy=0",
                 i, wl_a, bl_a, done_a, cfg_ready_a, busy_a);
      end
      n_checks++;
      if (wl_b !== '0 || bl_b !== '0 || done_b !== 1'b0 || cfg_ready_b !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_b cyc=%0d wl=%h bl=%h done=%b rdy=%b exp wl=0 bl=0 done=0 rdy=1",
                 i, wl_b, bl_b, done_b, cfg_ready_b);
      end
    end
    pReset      = 1'b0;
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    tick();
    n_checks++;
    if (cfg_ready_a !== 1'b1 || bl_a !== '0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept rdy=%b busy=%b bl=%h exp rdy=1 busy=0 bl=0", cfg_ready_a, busy_a, bl_a);
    end
  endtask

  // Full program on the default instance; cfg_data is scrambled while busy.
  task automatic test_program(input logic [0:63] word);
    int d;
    d = done_cyc(1, 2, 1);
    cfg_data    = word;
    cfg_valid_a = 1'b1;
    tick();
    cfg_valid_a = 1'b0;
    cfg_data    = rand_word();
    for (int c = 1; c <= d + 1; c++) begin
      n_checks++;
      if (wl_a !== exp_wl(c, 1, 2, 1)) begin
        n_fail++;
        $display("FAIL prog_wl c=%0d got=%h exp=%h", c, wl_a, exp_wl(c, 1, 2, 1));
      end
      n_checks++;
      if (bl_a !== exp_bl(c, 1, 2, 1, word)) begin
        n_fail++;
        $display("FAIL prog_bl c=%0d got=%h exp=%h", c, bl_a, exp_bl(c, 1, 2, 1, word));
      end
      n_checks++;
      if (done_a !== (c == d)) begin
        n_fail++;
        $display("FAIL prog_done c=%0d got=%b exp=%b", c, done_a, (c == d));
      end
      n_checks++;
      if (cfg_ready_a !== (c > d) || busy_a !== (c <= d)) begin
        n_fail++;
        $display("FAIL prog_rdy_busy c=%0d rdy=%b busy=%b exp rdy=%b busy=%b", c, cfg_ready_a, busy_a, (c > d), (c <= d));
      end
      if (c <= d) tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic [0:63] word;
    int d, inj;
    word = rand_word();
    d    = done_cyc(1, 2, 1);
    inj  = 2 + 3 * 20;
    cfg_data    = word;
    cfg_valid_a = 1'b1;
    tick();
    cfg_valid_a = 1'b0;
    for (int c = 1; c <= d + 2; c++) begin
      n_checks++;
      if (wl_a !== exp_wl(c, 1, 2, 1) || bl_a !== exp_bl(c, 1, 2, 1, word)) begin
        n_fail++;
        $display("FAIL ignore_wl_bl c=%0d wl=%h bl=%h exp wl=%h bl=%h", c, wl_a, bl_a,
                 exp_wl(c, 1, 2, 1), exp_bl(c, 1, 2, 1, word));
      end
      n_checks++;
      if (done_a !== (c == d) || cfg_ready_a !== (c > d)) begin
        n_fail++;
        $display("FAIL ignore_done_rdy c=%0d done=%b rdy=%b exp done=%b rdy=%b", c, done_a, cfg_ready_a, (c == d), (c > d));
      end
      cfg_valid_a = (c == inj);
      cfg_data    = (c == inj) ? ~word : word;
      if (c <= d + 1) tick();
    end
    cfg_valid_a = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    logic [0:63] word;
    logic        bad;
    int          stop;
    word = rand_word();
    stop = 3 + 3 * 10;
    cfg_data    = word;
    cfg_valid_a = 1'b1;
    tick();
    cfg_valid_a = 1'b0;
    for (int c = 1; c < stop; c++) tick();
    n_checks++;
    if (wl_a !== exp_wl(stop, 1, 2, 1)) begin
      n_fail++;
      $display("FAIL abort_pre_wl got=%h exp=%h", wl_a, exp_wl(stop, 1, 2, 1));
    end
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    n_checks++;
    if (wl_a !== '0 || bl_a !== '0 || cfg_ready_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state wl=%h bl=%h rdy=%b done=%b exp wl=0 bl=0 rdy=1 done=0", wl_a, bl_a, cfg_ready_a, done_a);
    end
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done_a !== 1'b0 || wl_a !== '0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet got=%b exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:63] w1, w2;
    int d;
    w1 = rand_word();
    w2 = rand_word();
    d  = done_cyc(1, 2, 1);
    cfg_data    = w1;
    cfg_valid_a = 1'b1;
    tick();
    cfg_data = w2;
    for (int c = 1; c <= d; c++) begin
      n_checks++;
      if (wl_a !== exp_wl(c, 1, 2, 1) || bl_a !== exp_bl(c, 1, 2, 1, w1) || done_a !== (c == d)) begin
        n_fail++;
        $display("FAIL b2b_first c=%0d wl=%h bl=%h done=%b exp wl=%h bl=%h done=%b", c, wl_a, bl_a, done_a,
                 exp_wl(c, 1, 2, 1), exp_bl(c, 1, 2, 1, w1), (c == d));
      end
      tick();
    end
    n_checks++;
    if (cfg_ready_a !== 1'b1 || bl_a !== '0) begin
      n_fail++;
      $display("FAIL b2b_gap rdy=%b bl=%h exp rdy=1 bl=0", cfg_ready_a, bl_a);
    end
    tick();
    cfg_valid_a = 1'b0;
    for (int c = 1; c <= d + 1; c++) begin
      n_checks++;
      if (wl_a !== exp_wl(c, 1, 2, 1) || bl_a !== exp_bl(c, 1, 2, 1, w2) || done_a !== (c == d)) begin
        n_fail++;
        $display("FAIL b2b_second c=%0d wl=%h bl=%h done=%b exp wl=%h bl=%h done=%b", c, wl_a, bl_a, done_a,
                 exp_wl(c, 1, 2, 1), exp_bl(c, 1, 2, 1, w2), (c == d));
      end
      if (c <= d) tick();
    end
  endtask

  task automatic test_params();
    logic [0:63] word;
    int d;
    word = rand_word();
    d    = done_cyc(2, 3, 2);
    cfg_data    = word;
    cfg_valid_b = 1'b1;
    tick();
    cfg_valid_b = 1'b0;
    cfg_data    = ~word;
    for (int c = 1; c <= d + 1; c++) begin
      n_checks++;
      if (wl_b !== exp_wl(c, 2, 3, 2) || bl_b !== exp_bl(c, 2, 3, 2, word)) begin
        n_fail++;
        $display("FAIL param_wl_bl c=%0d wl=%h bl=%h exp wl=%h bl=%h", c, wl_b, bl_b,
                 exp_wl(c, 2, 3, 2), exp_bl(c, 2, 3, 2, word));
      end
      n_checks++;
      if ($countones(wl_b) > 1) begin
        n_fail++;
        $display("FAIL param_onehot c=%0d got=%0d exp<=1", c, $countones(wl_b));
      end
      n_checks++;
      if (done_b !== (c == d) || cfg_ready_b !== (c > d)) begin
        n_fail++;
        $display("FAIL param_done_rdy c=%0d done=%b rdy=%b exp done=%b rdy=%b", c, done_b, cfg_ready_b, (c == d), (c > d));
      end
      if (c <= d) tick();
    end
  endtask

  initial begin
    pReset      = 1'b1;
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    cfg_data    = '0;
    test_reset();
    test_program(64'hA5A5_0000_FFFF_1234);
    test_program(rand_word());
    test_busy_ignore();
    test_reset_mid_pulse();
    test_back_to_back();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
